// File: rtl/ysyx_lsu_mem_resp_pkg.sv
// Shared state type, default base address and address-range helper for the
// LSU memory responder and any future bus targets built alongside it.
package ysyx_lsu_mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } respState_e;

    localparam logic [31:0] DEFAULT_BASE = 32'h8000_0000;

    // True when addr falls inside a window of 4*2^aw bytes starting at base.
    function automatic logic addrInRange(input logic [63:0] addr,
                                         input logic [63:0] base,
                                         input int unsigned aw);
        logic [63:0] offset;
        offset = addr - base;
        return (addr >= base) && ((offset >> (aw + 2)) == 64'd0);
    endfunction

endpackage

// File: rtl/ysyx_lsu_mem_resp_if.sv
// LSU load/store request bus; the LSU drives requests, the memory target
// drives registered single-cycle response pulses.
interface ysyx_lsu_mem_resp_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] lsu_araddr;
    logic            lsu_arvalid;
    logic [7:0]      lsu_rstrb;
    logic [XLEN-1:0] lsu_awaddr;
    logic            lsu_awvalid;
    logic [XLEN-1:0] lsu_wdata;
    logic [7:0]      lsu_wstrb;
    logic            lsu_wvalid;
    logic [XLEN-1:0] out_rdata;
    logic            out_rvalid;
    logic            out_wready;
    logic            out_err;

    modport master (
        output lsu_araddr, lsu_arvalid, lsu_rstrb,
        output lsu_awaddr, lsu_awvalid, lsu_wdata, lsu_wstrb, lsu_wvalid,
        input  out_rdata, out_rvalid, out_wready, out_err
    );

    modport slave (
        input  lsu_araddr, lsu_arvalid, lsu_rstrb,
        input  lsu_awaddr, lsu_awvalid, lsu_wdata, lsu_wstrb, lsu_wvalid,
        output out_rdata, out_rvalid, out_wready, out_err
    );
endinterface

// File: rtl/ysyx_lsu_store_align.sv
// Shifts right-justified store data and strobes into word lanes; bytes that
// would spill into the next word are simply dropped.
module ysyx_lsu_store_align #(
    parameter int XLEN = 32
) (
    input  logic [1:0]      shift_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [3:0]      wstrb_i,
    output logic [3:0]      be_o,
    output logic [XLEN-1:0] wordData_o
);

    always_comb begin
        be_o       = wstrb_i << shift_i;
        wordData_o = wdata_i << {shift_i, 3'b000};
    end

endmodule

// File: rtl/ysyx_lsu_mem_resp.sv
// Fixed-latency SRAM target for the LSU bus: accepts one load or store at a
// time and answers with a registered one-cycle pulse LATENCY edges later.
module ysyx_lsu_mem_resp
    import ysyx_lsu_mem_resp_pkg::*;
#(
    parameter int              XLEN    = 32,
    parameter int unsigned     MEM_AW  = 12,
    parameter logic [XLEN-1:0] BASE    = XLEN'(DEFAULT_BASE),
    parameter int              LATENCY = 2
) (
    input logic                 clock,
    input logic                 reset,
    ysyx_lsu_mem_resp_if.slave  bus
);

    localparam logic [3:0] LAT_LAST = 4'(LATENCY - 1);
    localparam int         DEPTH    = 2 ** MEM_AW;

    respState_e        state_q, state_d;
    logic [3:0]        count_q, count_d;
    logic              isStore_q, isStore_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [XLEN-1:0]   rdata_q;
    logic              rvalid_q, wready_q, err_q;
    logic              respond;
    logic              inRange;
    logic [XLEN-1:0]   offset;
    logic [MEM_AW-1:0] memIdx;
    logic [3:0]        be;
    logic [XLEN-1:0]   alignedWord;
    logic [XLEN-1:0]   mem [DEPTH];
    logic              unused_ok;

    // The read mask and upper store strobes carry no meaning for a word SRAM.
    assign unused_ok = ^{bus.lsu_rstrb, bus.lsu_wstrb[7:4]};

    assign offset  = addr_q - BASE;
    assign memIdx  = MEM_AW'(offset >> 2);
    assign inRange = addrInRange(64'(addr_q), 64'(BASE), MEM_AW);

    ysyx_lsu_store_align #(
        .XLEN(XLEN)
    ) u_align (
        .shift_i    (addr_q[1:0]),
        .wdata_i    (wdata_q),
        .wstrb_i    (wstrb_q),
        .be_o       (be),
        .wordData_o (alignedWord)
    );

    // BUSY counts down from LATENCY-1 to 0; the edge leaving count 0 enters
    // RESP and registers the pulse, so it is visible LATENCY edges after accept.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        isStore_d = isStore_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        respond   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.lsu_awvalid && bus.lsu_wvalid) begin
                    isStore_d = 1'b1;
                    addr_d    = bus.lsu_awaddr;
                    wdata_d   = bus.lsu_wdata;
                    wstrb_d   = bus.lsu_wstrb[3:0];
                    count_d   = LAT_LAST;
                    state_d   = BUSY;
                end else if (bus.lsu_arvalid) begin
                    isStore_d = 1'b0;
                    addr_d    = bus.lsu_araddr;
                    count_d   = LAT_LAST;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (count_q == 4'd0) begin
                    respond = 1'b1;
                    state_d = RESP;
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            count_q   <= 4'd0;
            isStore_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= 4'd0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            wready_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            isStore_q <= isStore_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rvalid_q  <= respond && !isStore_q;
            wready_q  <= respond && isStore_q;
            err_q     <= respond && !inRange;
            if (respond && !isStore_q) begin
                rdata_q <= inRange ? mem[memIdx] : '0;
            end
        end
    end

    // Storage is deliberately left unreset; out-of-range stores never land.
    always_ff @(posedge clock) begin
        if (respond && isStore_q && inRange) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[memIdx][8*b +: 8] <= alignedWord[8*b +: 8];
                end
            end
        end
    end

    assign bus.out_rdata  = rdata_q;
    assign bus.out_rvalid = rvalid_q;
    assign bus.out_wready = wready_q;
    assign bus.out_err    = err_q;

endmodule

// File: tb/tb_ysyx_lsu_mem_resp.sv
// Scoreboard bench for ysyx_lsu_mem_resp: three instances (LATENCY 1, 2, 4)
// share one request driver and a byte-level reference memory.
module tb_ysyx_lsu_mem_resp;

    typedef struct {
        bit          isStore;
        logic [31:0] data;
        bit          err;
        int          dueCyc;
    } expect_t;

    logic        clock = 1'b0;
    logic        reset;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          dutSel = 2;
    int          curLat = 2;

    logic [31:0] araddr, awaddr, wdata;
    logic [7:0]  rstrb, wstrb;
    logic        arvalid, awvalid, wvalid;
    logic [31:0] obsRdata;
    logic        obsRvalid, obsWready, obsErr;

    expect_t     sbQ[$];
    logic [31:0] model [longint];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    ysyx_lsu_mem_resp_if #(.XLEN(32)) bus1 ();
    ysyx_lsu_mem_resp_if #(.XLEN(32)) bus2 ();
    ysyx_lsu_mem_resp_if #(.XLEN(32)) bus4 ();

    assign bus1.lsu_araddr = araddr; assign bus1.lsu_awaddr = awaddr; assign bus1.lsu_wdata = wdata;
    assign bus1.lsu_rstrb = rstrb;   assign bus1.lsu_wstrb = wstrb;
    assign bus1.lsu_arvalid = arvalid && (dutSel == 1);
    assign bus1.lsu_awvalid = awvalid && (dutSel == 1);
    assign bus1.lsu_wvalid  = wvalid && (dutSel == 1);
    assign bus2.lsu_araddr = araddr; assign bus2.lsu_awaddr = awaddr; assign bus2.lsu_wdata = wdata;
    assign bus2.lsu_rstrb = rstrb;   assign bus2.lsu_wstrb = wstrb;
    assign bus2.lsu_arvalid = arvalid && (dutSel == 2);
    assign bus2.lsu_awvalid = awvalid && (dutSel == 2);
    assign bus2.lsu_wvalid  = wvalid && (dutSel == 2);
    assign bus4.lsu_araddr = araddr; assign bus4.lsu_awaddr = awaddr; assign bus4.lsu_wdata = wdata;
    assign bus4.lsu_rstrb = rstrb;   assign bus4.lsu_wstrb = wstrb;
    assign bus4.lsu_arvalid = arvalid && (dutSel == 4);
    assign bus4.lsu_awvalid = awvalid && (dutSel == 4);
    assign bus4.lsu_wvalid  = wvalid && (dutSel == 4);

    ysyx_lsu_mem_resp #(.LATENCY(1)) dut1 (.clock(clock), .reset(reset), .bus(bus1));
    ysyx_lsu_mem_resp #(.LATENCY(2)) dut2 (.clock(clock), .reset(reset), .bus(bus2));
    ysyx_lsu_mem_resp #(.LATENCY(4)) dut4 (.clock(clock), .reset(reset), .bus(bus4));

    always_comb begin
        obsRdata  = bus2.out_rdata;
        obsRvalid = bus2.out_rvalid;
        obsWready = bus2.out_wready;
        obsErr    = bus2.out_err;
        if (dutSel == 1) begin
            obsRdata  = bus1.out_rdata;
            obsRvalid = bus1.out_rvalid;
            obsWready = bus1.out_wready;
            obsErr    = bus1.out_err;
        end else if (dutSel == 4) begin
            obsRdata  = bus4.out_rdata;
            obsRvalid = bus4.out_rvalid;
            obsWready = bus4.out_wready;
            obsErr    = bus4.out_err;
        end
    end

    function automatic bit inRangeModel(input logic [31:0] a);
        return (a >= 32'h8000_0000) && (a <= 32'h8000_3FFF);
    endfunction

    function automatic longint mkKey(input logic [31:0] a);
        return (longint'(dutSel) << 32) | longint'({a[31:2], 2'b00});
    endfunction

    function automatic logic [31:0] modelLoad(input logic [31:0] a);
        if (!inRangeModel(a)) return 32'h0;
        if (!model.exists(mkKey(a))) return 'x;
        return model[mkKey(a)];
    endfunction

    // Byte lane b receives source byte (b - offset) when that byte is strobed.
    function automatic void modelStore(input logic [31:0] a, input logic [31:0] d,
                                       input logic [7:0] s);
        logic [31:0] w;
        int src;
        if (!inRangeModel(a)) return;
        w = model.exists(mkKey(a)) ? model[mkKey(a)] : 'x;
        for (int b = 0; b < 4; b++) begin
            src = b - int'(a[1:0]);
            if (src >= 0 && s[src]) w[8*b +: 8] = d[8*src +: 8];
        end
        model[mkKey(a)] = w;
    endfunction

    task automatic issueReq(input bit doStore, input bit doLoad, input logic [31:0] addr,
                            input logic [31:0] data, input logic [7:0] strb);
        expect_t e;
        int      base;
        @(posedge clock);
        #1;
        base    = cyc;
        araddr  = addr;
        awaddr  = addr;
        wdata   = data;
        wstrb   = strb;
        rstrb   = 8'h0F;
        arvalid = doLoad;
        awvalid = doStore;
        wvalid  = doStore;
        if (doStore) begin
            modelStore(addr, data, strb);
            e.isStore = 1'b1;
            e.data    = 32'h0;
            e.err     = !inRangeModel(addr);
            e.dueCyc  = base + 1 + curLat;
            sbQ.push_back(e);
        end
        if (doLoad) begin
            e.isStore = 1'b0;
            e.data    = modelLoad(addr);
            e.err     = !inRangeModel(addr);
            e.dueCyc  = doStore ? base + 3 + 2 * curLat : base + 1 + curLat;
            sbQ.push_back(e);
        end
    endtask

    task automatic waitResp(input string name);
        expect_t e;
        bit      seen = 1'b0;
        e = sbQ.pop_front();
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clock);
            seen = obsRvalid || obsWready;
        end
        checks++;
        if (!seen) begin
            $display("[TB] FAIL %s timeout: rvalid/wready stayed low for 40 cycles, expected a response", name);
            errors++;
        end else begin
            checks++;
            if (cyc !== e.dueCyc) begin
                $display("[TB] FAIL %s latency: pulse at cycle %0d, expected %0d", name, cyc, e.dueCyc);
                errors++;
            end
            checks++;
            if (obsWready !== e.isStore || obsRvalid !== !e.isStore) begin
                $display("[TB] FAIL %s kind: wready=%b rvalid=%b, expected store=%b",
                         name, obsWready, obsRvalid, e.isStore);
                errors++;
            end
            checks++;
            if (obsErr !== e.err) begin
                $display("[TB] FAIL %s err: got %b, expected %b", name, obsErr, e.err);
                errors++;
            end
            if (!e.isStore) begin
                checks++;
                if (obsRdata !== e.data) begin
                    $display("[TB] FAIL %s rdata: got %h, expected %h", name, obsRdata, e.data);
                    errors++;
                end
            end
        end
        if (e.isStore) begin
            awvalid = 1'b0;
            wvalid  = 1'b0;
        end else begin
            arvalid = 1'b0;
        end
        @(negedge clock);
        checks++;
        if (obsRvalid || obsWready || obsErr) begin
            $display("[TB] FAIL %s width: pulses still high (rv=%b wr=%b err=%b), expected 0",
                     name, obsRvalid, obsWready, obsErr);
            errors++;
        end
    endtask

    task automatic test_reset;
        int sels[3] = '{1, 2, 4};
        reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        foreach (sels[i]) begin
            dutSel = sels[i];
            #1;
            checks++;
            if ({obsRdata, obsRvalid, obsWready, obsErr} !== 35'd0) begin
                $display("[TB] FAIL reset_L%0d: outputs %h/%b%b%b, expected all 0",
                         dutSel, obsRdata, obsRvalid, obsWready, obsErr);
                errors++;
            end
        end
        dutSel = 2;
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_store_load;
        dutSel = 2; curLat = 2;
        issueReq(1, 0, 32'h8000_0010, 32'hDEAD_BEEF, 8'h0F); waitResp("basic_store");
        issueReq(0, 1, 32'h8000_0010, 32'h0, 8'h00);         waitResp("basic_load");
        issueReq(1, 0, 32'h8000_0014, 32'h0BAD_F00D, 8'h0F); waitResp("hold_store");
        checks++;
        if (obsRdata !== 32'hDEAD_BEEF) begin
            $display("[TB] FAIL rdata_hold: got %h, expected deadbeef", obsRdata);
            errors++;
        end
    endtask

    task automatic test_byte_merge;
        issueReq(1, 0, 32'h8000_0010, 32'h1122_3344, 8'h0F); waitResp("merge_fill");
        issueReq(1, 0, 32'h8000_0013, 32'h0000_00AB, 8'h01); waitResp("merge_byte");
        issueReq(0, 1, 32'h8000_0010, 32'h0, 8'h00);         waitResp("merge_load");
    endtask

    task automatic test_word_cross;
        issueReq(1, 0, 32'h8000_0020, 32'h0102_0304, 8'h0F); waitResp("cross_fill0");
        issueReq(1, 0, 32'h8000_0024, 32'h0506_0708, 8'h0F); waitResp("cross_fill1");
        issueReq(1, 0, 32'h8000_0023, 32'h0000_CAFE, 8'h03); waitResp("cross_store");
        issueReq(0, 1, 32'h8000_0020, 32'h0, 8'h00);         waitResp("cross_load0");
        issueReq(0, 1, 32'h8000_0024, 32'h0, 8'h00);         waitResp("cross_load1");
    endtask

    task automatic test_priority;
        issueReq(1, 1, 32'h8000_0030, 32'h0000_0005, 8'h0F);
        waitResp("prio_store");
        waitResp("prio_load");
    endtask

    task automatic test_out_of_range;
        issueReq(1, 0, 32'h8000_0000, 32'hA5A5_A5A5, 8'h0F); waitResp("oor_fill_lo");
        issueReq(1, 0, 32'h8000_3FFC, 32'h5A5A_5A5A, 8'h0F); waitResp("oor_fill_hi");
        issueReq(0, 1, 32'h9000_0000, 32'h0, 8'h00);         waitResp("oor_load");
        issueReq(1, 0, 32'h7FFF_FFFC, 32'hFFFF_FFFF, 8'h0F); waitResp("oor_store");
        issueReq(0, 1, 32'h8000_3FFC, 32'h0, 8'h00);         waitResp("oor_check_hi");
        issueReq(0, 1, 32'h8000_0000, 32'h0, 8'h00);         waitResp("oor_check_lo");
    endtask

    task automatic test_zero_strobe;
        issueReq(1, 0, 32'h8000_0010, 32'hFFFF_FFFF, 8'h00); waitResp("zstrb_store");
        issueReq(0, 1, 32'h8000_0010, 32'h0, 8'h00);         waitResp("zstrb_load");
    endtask

    task automatic test_back_to_back;
        logic [31:0] a;
        for (int i = 0; i < 8; i++) begin
            issueReq(1, 0, 32'h8000_0200 + 32'(4 * i), $urandom, 8'h0F);
            waitResp("b2b_fill");
        end
        for (int i = 0; i < 8; i++) begin
            a = 32'h8000_0200 + 32'($urandom_range(0, 28));
            issueReq(1, 0, a, $urandom, 8'($urandom_range(0, 255)));
            waitResp("b2b_store");
            issueReq(0, 1, a, 32'h0, 8'h00);
            waitResp("b2b_load");
        end
    endtask

    task automatic test_reset_abort;
        int pulses = 0;
        dutSel = 4; curLat = 4;
        issueReq(1, 0, 32'h8000_0040, 32'h1234_5678, 8'h0F); waitResp("abort_fill");
        @(posedge clock); #1;
        awaddr = 32'h8000_0040; wdata = 32'hFFFF_FFFF; wstrb = 8'h0F;
        awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clock);
        checks++;
        if ({obsRdata, obsRvalid, obsWready, obsErr} !== 35'd0) begin
            $display("[TB] FAIL abort_in_reset: outputs %h/%b%b%b, expected all 0",
                     obsRdata, obsRvalid, obsWready, obsErr);
            errors++;
        end
        @(posedge clock); #1;
        reset = 1'b1;
        repeat (10) begin
            @(negedge clock);
            if (obsRvalid || obsWready) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            $display("[TB] FAIL abort_pulse: saw %0d pulses, expected 0", pulses);
            errors++;
        end
        issueReq(0, 1, 32'h8000_0040, 32'h0, 8'h00); waitResp("abort_readback");
    endtask

    task automatic test_latency_one;
        dutSel = 1; curLat = 1;
        issueReq(1, 0, 32'h8000_0100, 32'hA1B2_C3D4, 8'h0F); waitResp("lat1_store");
        issueReq(0, 1, 32'h8000_0100, 32'h0, 8'h00);         waitResp("lat1_load");
        dutSel = 2; curLat = 2;
    endtask

    initial begin
        araddr = '0; awaddr = '0; wdata = '0; rstrb = '0; wstrb = '0;
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        test_reset();
        test_store_load();
        test_byte_merge();
        test_word_cross();
        test_priority();
        test_out_of_range();
        test_zero_strobe();
        test_back_to_back();
        test_reset_abort();
        test_latency_one();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
